// File: rtl/debug_mem_loader_pkg.sv
// Shared definitions for the debug memory loader: FSM state encoding, command
// byte field positions, default response bytes and the command legality check.
// Configuration macro: DEBUG_LOADER_AUTOINC_EN (address auto-increment / burst load).
package debug_mem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StWrite,
    StRdWait,
    StResp,
    StErr
  } state_e;

  // Command byte fields
  localparam int unsigned CMD_TARGET_BIT = 7;  // 0 InstRAM, 1 DataRAM
  localparam int unsigned CMD_AUTO_BIT   = 1;  // use auto-increment address register
  localparam int unsigned CMD_OP_BIT     = 0;  // 0 read, 1 write

  localparam logic [7:0] DEF_ACK_BYTE = 8'hA5;
  localparam logic [7:0] DEF_ERR_BYTE = 8'hEE;

  // Reserved bits [6:2] must be zero; bit 1 only legal with auto-increment built in.
  function automatic logic cmd_legal(input logic [7:0] cmd, input logic autoinc_en);
    return (cmd[6:2] == 5'd0) && (autoinc_en || !cmd[CMD_AUTO_BIT]);
  endfunction

endpackage

// File: rtl/dbg_word_shifter.sv
// 32-bit little-endian byte assembler / serializer.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : reset byte index to 0
//   i_push, i_byte : store i_byte at the current index, advance index
//   i_load, i_word : load a whole word, index back to 0
//   i_pop          : advance index (serializer side)
//   o_word         : assembled word
//   o_byte         : byte at current index
//   o_idx          : current byte index
module dbg_word_shifter (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_push,
  input  logic [7:0]  i_byte,
  input  logic        i_load,
  input  logic [31:0] i_word,
  input  logic        i_pop,
  output logic [31:0] o_word,
  output logic [7:0]  o_byte,
  output logic [1:0]  o_idx
);

  logic [31:0] r_word;
  logic [1:0]  r_idx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word <= 32'd0;
      r_idx  <= 2'd0;
    end else if (i_clr) begin
      r_idx <= 2'd0;
    end else if (i_load) begin
      r_word <= i_word;
      r_idx  <= 2'd0;
    end else if (i_push) begin
      r_word[{r_idx, 3'b000} +: 8] <= i_byte;
      r_idx <= r_idx + 2'd1;
    end else if (i_pop) begin
      r_idx <= r_idx + 2'd1;
    end
  end

  assign o_word = r_word;
  assign o_byte = r_word[{r_idx, 3'b000} +: 8];
  assign o_idx  = r_idx;

endmodule

// File: rtl/debug_mem_loader.sv
// Byte-stream master for the core's debug memory port 2 (InstRAM / DataRAM).
// Host bytes on the rx stream are decoded into single-word reads and writes;
// read data, write acks and error bytes go back on the tx stream.
// Configuration macro: DEBUG_LOADER_AUTOINC_EN (cmd[1]=1 reuses an internal address
// register that tracks the last access + 4; otherwise cmd[1]=1 is illegal).
// Ports:
//   i_clk, i_rst_n                 : clock, asynchronous active-low reset
//   i_rx_data/i_rx_valid/o_rx_ready : command/payload byte stream in
//   o_tx_data/o_tx_valid/i_tx_ready : response byte stream out
//   o_inst_a2/wd2/we2, i_inst_rd2   : InstRAM port 2
//   o_data_a2/wd2/we2, i_data_rd2   : DataRAM port 2
//   o_busy                          : high whenever not idle
module debug_mem_loader
  import debug_mem_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned RD_LATENCY     = 1,
  parameter logic [7:0]  ACK_BYTE       = DEF_ACK_BYTE,
  parameter logic [7:0]  ERR_BYTE       = DEF_ERR_BYTE
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic [31:0] o_inst_a2,
  output logic [31:0] o_inst_wd2,
  output logic [3:0]  o_inst_we2,
  input  logic [31:0] i_inst_rd2,
  output logic [31:0] o_data_a2,
  output logic [31:0] o_data_wd2,
  output logic [3:0]  o_data_we2,
  input  logic [31:0] i_data_rd2,
  output logic        o_busy
);

`ifdef DEBUG_LOADER_AUTOINC_EN
  localparam logic AUTOINC_EN = 1'b1;
`else
  localparam logic AUTOINC_EN = 1'b0;
`endif

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e             r_state, w_state_d;
  logic               r_tgt, r_wr;
  logic [31:0]        r_addr;
  logic [TMR_W-1:0]   r_timer;
  logic [1:0]         r_lat;

  logic               w_rx_ready, w_accept, w_tx_valid, w_tx_hs, w_timeout;
  logic               w_sh_clr, w_sh_push, w_sh_load, w_sh_pop;
  logic [31:0]        w_sh_word, w_rd_word;
  logic [7:0]         w_sh_byte;
  logic [1:0]         w_sh_idx;
  logic               w_cmd_take, w_addr_load, w_use_auto, w_access_done;
  logic               w_mem_active;

`ifdef DEBUG_LOADER_AUTOINC_EN
  logic [31:0]        r_auto;
`endif

  assign w_rx_ready = (r_state == StIdle) || (r_state == StAddr) || (r_state == StData);
  assign w_accept   = i_rx_valid && w_rx_ready;
  assign w_tx_valid = (r_state == StResp) || (r_state == StErr);
  assign w_tx_hs    = w_tx_valid && i_tx_ready;
  assign w_timeout  = (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
  assign w_rd_word  = r_tgt ? i_data_rd2 : i_inst_rd2;

  dbg_word_shifter u_shifter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_sh_clr),
    .i_push  (w_sh_push),
    .i_byte  (i_rx_data),
    .i_load  (w_sh_load),
    .i_word  (w_rd_word),
    .i_pop   (w_sh_pop),
    .o_word  (w_sh_word),
    .o_byte  (w_sh_byte),
    .o_idx   (w_sh_idx)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_sh_clr      = 1'b0;
    w_sh_push     = 1'b0;
    w_sh_load     = 1'b0;
    w_sh_pop      = 1'b0;
    w_cmd_take    = 1'b0;
    w_addr_load   = 1'b0;
    w_use_auto    = 1'b0;
    w_access_done = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_sh_clr = 1'b1;
          if (!cmd_legal(i_rx_data, AUTOINC_EN)) begin
            w_state_d = StErr;
          end else begin
            w_cmd_take = 1'b1;
            w_state_d  = StAddr;
`ifdef DEBUG_LOADER_AUTOINC_EN
            if (i_rx_data[CMD_AUTO_BIT]) begin
              w_use_auto = 1'b1;
              w_state_d  = i_rx_data[CMD_OP_BIT] ? StData : StRdWait;
            end
`endif
          end
        end
      end
      StAddr: begin
        if (w_accept) begin
          w_sh_push = 1'b1;
          if (w_sh_idx == 2'd3) begin
            w_addr_load = 1'b1;
            w_state_d   = r_wr ? StData : StRdWait;
          end
        end else if (w_timeout) begin
          w_state_d = StIdle;
        end
      end
      StData: begin
        if (w_accept) begin
          w_sh_push = 1'b1;
          if (w_sh_idx == 2'd3) w_state_d = StWrite;
        end else if (w_timeout) begin
          w_state_d = StIdle;
        end
      end
      StWrite: begin
        w_access_done = 1'b1;
        w_state_d     = StResp;
      end
      StRdWait: begin
        // RD2 is sampled on the last of RD_LATENCY address cycles
        if (r_lat == 2'(RD_LATENCY - 1)) begin
          w_sh_load     = 1'b1;
          w_access_done = 1'b1;
          w_state_d     = StResp;
        end
      end
      StResp: begin
        if (w_tx_hs) begin
          if (r_wr || (w_sh_idx == 2'd3)) w_state_d = StIdle;
          else                            w_sh_pop  = 1'b1;
        end
      end
      StErr: begin
        if (w_tx_hs) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tgt   <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= 32'd0;
      r_timer <= '0;
      r_lat   <= 2'd0;
    end else begin
      if (w_cmd_take) begin
        r_tgt <= i_rx_data[CMD_TARGET_BIT];
        r_wr  <= i_rx_data[CMD_OP_BIT];
      end
      if (w_addr_load) begin
        r_addr <= {i_rx_data, w_sh_word[23:0]};
      end
`ifdef DEBUG_LOADER_AUTOINC_EN
      else if (w_use_auto) begin
        r_addr <= r_auto;
      end
`endif
      // Idle-gap counter only runs while a command is partially received
      if (w_accept || !((r_state == StAddr) || (r_state == StData))) r_timer <= '0;
      else                                                           r_timer <= r_timer + TMR_W'(1);
      if (r_state == StRdWait) r_lat <= r_lat + 2'd1;
      else                     r_lat <= 2'd0;
    end
  end

`ifdef DEBUG_LOADER_AUTOINC_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_auto <= 32'd0;
    end else if (w_access_done) begin
      r_auto <= r_addr + 32'd4;
    end
  end
`endif

  // Memory port drive: only the selected port sees address/data, and only while accessing
  assign w_mem_active = (r_state == StWrite) || (r_state == StRdWait);

  always_comb begin
    o_inst_a2  = 32'd0;
    o_inst_wd2 = 32'd0;
    o_inst_we2 = 4'h0;
    o_data_a2  = 32'd0;
    o_data_wd2 = 32'd0;
    o_data_we2 = 4'h0;
    if (w_mem_active) begin
      if (r_tgt) o_data_a2 = r_addr;
      else       o_inst_a2 = r_addr;
    end
    if (r_state == StWrite) begin
      if (r_tgt) begin
        o_data_wd2 = w_sh_word;
        o_data_we2 = 4'hF;
      end else begin
        o_inst_wd2 = w_sh_word;
        o_inst_we2 = 4'hF;
      end
    end
  end

  always_comb begin
    o_tx_data = 8'd0;
    if (r_state == StErr)       o_tx_data = ERR_BYTE;
    else if (r_state == StResp) o_tx_data = r_wr ? ACK_BYTE : w_sh_byte;
  end

  assign o_tx_valid = w_tx_valid;
  assign o_rx_ready = w_rx_ready;
  assign o_busy     = (r_state != StIdle);

endmodule

// File: tb/tb_debug_mem_loader.sv
module tb_debug_mem_loader;

  localparam int unsigned TB_TMO = 40;
  localparam int unsigned TB_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] inst_a2, inst_wd2, inst_rd2;
  logic [3:0]  inst_we2;
  logic [31:0] data_a2, data_wd2, data_rd2;
  logic [3:0]  data_we2;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pulses = 0;
  int exp_pulses = 0;

  typedef struct {
    bit          tgt;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_wq[$];
  wr_t         mon_w;
  logic [31:0] ram_i [0:255];
  logic [31:0] ram_d [0:255];
  logic [31:0] ref_i [0:255];
  logic [31:0] ref_d [0:255];
`ifdef DEBUG_LOADER_AUTOINC_EN
  logic [31:0] ref_auto = 32'd0;
`endif

  always #5 clk = ~clk;

  debug_mem_loader #(
    .TIMEOUT_CYCLES (TB_TMO),
    .RD_LATENCY     (TB_LAT)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_rx_ready (rx_ready),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .o_inst_a2  (inst_a2),
    .o_inst_wd2 (inst_wd2),
    .o_inst_we2 (inst_we2),
    .i_inst_rd2 (inst_rd2),
    .o_data_a2  (data_a2),
    .o_data_wd2 (data_wd2),
    .o_data_we2 (data_we2),
    .i_data_rd2 (data_rd2),
    .o_busy     (busy)
  );

  // Asynchronous-read RAM model; the address low bits are ignored
  assign inst_rd2 = ram_i[inst_a2[9:2]];
  assign data_rd2 = ram_d[data_a2[9:2]];

  function automatic logic [31:0] init_word(input bit tgt, input int idx);
    if (tgt && idx == 2) return 32'h1234_5678;
    return {tgt ? 8'hD0 : 8'h10, 8'(idx), 16'(idx * 40503)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // RAM side: applies observed write pulses and checks them against the expected queue
  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_i[i] = init_word(1'b0, i);
      ram_d[i] = init_word(1'b1, i);
    end
    forever begin
      @(negedge clk);
      if (inst_we2 != 4'h0 || data_we2 != 4'h0) begin
        n_pulses++;
        if (exp_wq.size() == 0) begin
          check("spurious_we", {24'd0, inst_we2, data_we2}, 32'd0);
        end else begin
          mon_w = exp_wq.pop_front();
          if (mon_w.tgt) begin
            check("d_we2", {28'd0, data_we2}, 32'hF);
            check("d_a2", data_a2, mon_w.addr);
            check("d_wd2", data_wd2, mon_w.data);
            check("i_we2_off", {28'd0, inst_we2}, 32'd0);
            check("i_a2_off", inst_a2 | inst_wd2, 32'd0);
            ram_d[data_a2[9:2]] = data_wd2;
          end else begin
            check("i_we2", {28'd0, inst_we2}, 32'hF);
            check("i_a2", inst_a2, mon_w.addr);
            check("i_wd2", inst_wd2, mon_w.data);
            check("d_we2_off", {28'd0, data_we2}, 32'd0);
            check("d_a2_off", data_a2 | data_wd2, 32'd0);
            ram_i[inst_a2[9:2]] = inst_wd2;
          end
        end
      end
    end
  end

  // Called at a negedge; presents one byte, waits for the handshake, then idles gap cycles
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("rx_ready_wait", 32'd0, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = $urandom;
    repeat (gap) @(negedge clk);
  endtask

  // Collects n response bytes (LSB first of word) under random or forced backpressure
  task automatic collect(input logic [31:0] word, input int n, input bit bp);
    int k = 0;
    int waitc = 0;
    int stall = 0;
    bit held_v = 0;
    logic [7:0] held = 8'd0;
    logic [31:0] w = word;
    bit rdy;
    while (k < n) begin
      if (!tx_valid) begin
        waitc++;
        if (waitc > 200) begin
          check("tx_valid_wait", 32'd0, 32'd1);
          tx_ready = 1'b0;
          return;
        end
        tx_ready = ($urandom_range(0, 1) == 0);
      end else begin
        if (held_v) check("tx_hold", {24'd0, tx_data}, {24'd0, held});
        if (bp && k == 2 && stall < 10) begin
          rdy = 1'b0;
          stall++;
        end else begin
          rdy = ($urandom_range(0, 2) != 0);
        end
        tx_ready = rdy;
        if (rdy) begin
          check("tx_byte", {24'd0, tx_data}, {24'd0, w[8*k +: 8]});
          check("rx_ready_resp", {31'd0, rx_ready}, 32'd0);
          k++;
          held_v = 0;
        end else begin
          held   = tx_data;
          held_v = 1;
        end
      end
      @(negedge clk);
    end
    tx_ready = 1'b0;
    check("resp_end", {30'd0, tx_valid, busy}, 32'd0);
  endtask

  task automatic do_cmd(input bit tgt, input bit wr, input bit use_auto, input logic [4:0] junk,
                        input logic [31:0] addr, input logic [31:0] data, input bit bp);
    logic [7:0]  cmd;
    logic [31:0] ea;
    logic [31:0] rd;
    bit          legal;
    cmd = {tgt, junk, use_auto, wr};
`ifdef DEBUG_LOADER_AUTOINC_EN
    legal = (junk == 5'd0);
    ea    = use_auto ? ref_auto : addr;
`else
    legal = (junk == 5'd0) && !use_auto;
    ea    = addr;
`endif
    send_byte(cmd, $urandom_range(0, 3));
    if (!legal) begin
      collect({24'd0, 8'hEE}, 1, 1'b0);
      return;
    end
    if (!use_auto) for (int i = 0; i < 4; i++) send_byte(ea[8*i +: 8], $urandom_range(0, 3));
    if (wr) begin
      exp_wq.push_back('{tgt: tgt, addr: ea, data: data});
      exp_pulses++;
      if (tgt) ref_d[ea[9:2]] = data;
      else     ref_i[ea[9:2]] = data;
      for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8], $urandom_range(0, 3));
    end
`ifdef DEBUG_LOADER_AUTOINC_EN
    ref_auto = ea + 32'd4;
`endif
    if (wr) begin
      collect({24'd0, 8'hA5}, 1, bp);
    end else begin
      rd = tgt ? ref_d[ea[9:2]] : ref_i[ea[9:2]];
      collect(rd, 4, bp);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    tx_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ref_i[i] = init_word(1'b0, i);
      ref_d[i] = init_word(1'b1, i);
    end
    repeat (3) @(negedge clk);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_a2", inst_a2 | data_a2, 32'd0);
    check("rst_wd2", inst_wd2 | data_wd2, 32'd0);
    check("rst_we2", {24'd0, inst_we2, data_we2}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write InstRAM 0x100, read DataRAM 0x08 with a 10-cycle stall mid-response
    do_cmd(1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
    do_cmd(1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0008, 32'd0, 1'b1);
    // Illegal 0x84, then a legal read-back
    do_cmd(1'b1, 1'b0, 1'b0, 5'b00001, 32'd0, 32'd0, 1'b0);
    do_cmd(1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_0100, 32'd0, 1'b0);

`ifdef DEBUG_LOADER_AUTOINC_EN
    do_cmd(1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0200, 32'hCAFE_0001, 1'b0);
    do_cmd(1'b0, 1'b1, 1'b1, 5'd0, 32'd0, 32'hCAFE_0002, 1'b0);
    do_cmd(1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_0204, 32'd0, 1'b0);
    do_cmd(1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'd0, 1'b0);
`else
    do_cmd(1'b0, 1'b1, 1'b1, 5'd0, 32'd0, 32'd0, 1'b0);
`endif

    // A gap of TIMEOUT-1 idle cycles between every byte still completes
    begin
      logic [31:0] a = 32'h0000_0031;
      logic [31:0] d = 32'h0BAD_F00D;
      send_byte(8'h81, TB_TMO - 1);
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], TB_TMO - 1);
      check("tmo_edge_alive", {31'd0, busy}, 32'd1);
      exp_wq.push_back('{tgt: 1'b1, addr: a, data: d});
      exp_pulses++;
      ref_d[a[9:2]] = d;
`ifdef DEBUG_LOADER_AUTOINC_EN
      ref_auto = a + 32'd4;
`endif
      for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], TB_TMO - 1);
      collect({24'd0, 8'hA5}, 1, 1'b0);
    end

    // A gap of TIMEOUT idle cycles aborts silently
    send_byte(8'h81, 0);
    send_byte(8'h00, TB_TMO);
    check("tmo_abort_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    check("tmo_abort_tx", {31'd0, tx_valid}, 32'd0);
    do_cmd(1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0031, 32'd0, 1'b0);

    // Reset in the middle of a write's data phase
    send_byte(8'h01, 0);
    for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i), 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_we2", {24'd0, inst_we2, data_we2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef DEBUG_LOADER_AUTOINC_EN
    ref_auto = 32'd0;
`endif
    repeat (2) @(negedge clk);
    check("midrst_tx", {31'd0, tx_valid}, 32'd0);
    do_cmd(1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_0143, 32'd0, 1'b0);

    // Randomized traffic against the reference memories
    for (int n = 0; n < 60; n++) begin
      logic [4:0] junk;
      junk = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      do_cmd(1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0), junk,
             $urandom, $urandom, ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    check("pulse_count", n_pulses, exp_pulses);
    check("wq_drained", exp_wq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
